// File: rtl/gray_seq_monitor_pkg.sv
// Shared types and the Gray-to-binary helper for the Gray sequence monitor.
// The helper works on a fixed maximum width so that narrower callers can zero-extend into it.
package gray_mon_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {ST_EMPTY, ST_SYNC, ST_LOCKED} gray_mon_state_t;

  typedef enum {STEP_INC, STEP_HOLD, STEP_DEC, STEP_ILLEGAL} gray_step_t;

  // Leading zeros decode to zeros, so a zero-extended narrow word keeps its value.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_seq_monitor_if.sv
// Sample/result bundle between a Gray counter (master) and the sequence monitor (slave).
// No backpressure: the monitor accepts every valid sample.
interface gray_seq_monitor_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ERR_W      = 8
);

  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] bin_out;
  logic                  bin_valid;
  logic                  step_err;
  logic [ERR_W-1:0]      err_count;
  logic                  locked;

  modport master (
    output din, din_valid,
    input  bin_out, bin_valid, step_err, err_count, locked
  );

  modport slave (
    input  din, din_valid,
    output bin_out, bin_valid, step_err, err_count, locked
  );

endinterface

// File: rtl/gray_seq_monitor_gray2bin_dec.sv
// Combinational Gray-to-binary decoder, zero latency, no backpressure.
module gray2bin_dec
  import gray_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] i_gray,
  output logic [DATA_WIDTH-1:0] o_bin
);

  logic [GRAY_MAX_W-1:0] w_bin_ext;
  logic                  w_unused_hi;

  assign w_bin_ext   = gray2bin(GRAY_MAX_W'(i_gray));
  assign o_bin       = w_bin_ext[DATA_WIDTH-1:0];
  assign w_unused_hi = ^w_bin_ext;

endmodule

// File: rtl/gray_seq_monitor.sv
// Gray sequence monitor: decodes samples, classifies steps, tracks lock and a saturating error count.
// 1-cycle latency, no backpressure; GRAY_MON_DOWN_EN also accepts down-counting steps.
module gray_seq_monitor
  import gray_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ERR_W      = 8,
  parameter int LOCK_STEPS = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  gray_seq_monitor_if.slave mon_bus
);

  localparam int             GOOD_W  = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  gray_mon_state_t       r_state;
  logic [GOOD_W-1:0]     r_good;
  logic [DATA_WIDTH-1:0] r_pb;
  logic [DATA_WIDTH-1:0] r_bin_out;
  logic                  r_bin_valid;
  logic                  r_step_err;
  logic [ERR_W-1:0]      r_err_count;

  gray_mon_state_t       w_state_nxt;
  logic [GOOD_W-1:0]     w_good_nxt;
  logic [GOOD_W-1:0]     w_good_inc;
  logic [DATA_WIDTH-1:0] w_pb_nxt;
  logic [DATA_WIDTH-1:0] w_bin_out_nxt;
  logic                  w_bin_valid_nxt;
  logic                  w_step_err_nxt;
  logic [ERR_W-1:0]      w_err_count_nxt;

  logic [DATA_WIDTH-1:0] w_nb;
  logic [DATA_WIDTH-1:0] w_pb_inc;
  logic [DATA_WIDTH-1:0] w_pb_dec;
  gray_step_t            w_step;
  logic                  w_good_step;

  gray2bin_dec #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_dec (
    .i_gray(mon_bus.din),
    .o_bin (w_nb)
  );

  assign w_pb_inc   = r_pb + DATA_WIDTH'(1);
  assign w_pb_dec   = r_pb - DATA_WIDTH'(1);
  assign w_good_inc = r_good + GOOD_W'(1);

  always_comb begin
    w_step = STEP_ILLEGAL;
    if (w_nb == w_pb_inc) begin
      w_step = STEP_INC;
    end else if (w_nb == r_pb) begin
      w_step = STEP_HOLD;
`ifdef GRAY_MON_DOWN_EN
    end else if (w_nb == w_pb_dec) begin
      w_step = STEP_DEC;
`endif
    end
  end

  assign w_good_step = (w_step == STEP_INC) || (w_step == STEP_DEC);

  always_comb begin
    w_state_nxt     = r_state;
    w_good_nxt      = r_good;
    w_pb_nxt        = r_pb;
    w_bin_out_nxt   = r_bin_out;
    w_bin_valid_nxt = 1'b0;
    w_step_err_nxt  = 1'b0;
    w_err_count_nxt = r_err_count;

    if (mon_bus.din_valid) begin
      // pb follows every sample, legal or not, so the monitor re-phases after a glitch
      w_pb_nxt        = w_nb;
      w_bin_out_nxt   = w_nb;
      w_bin_valid_nxt = 1'b1;

      case (r_state)
        ST_EMPTY: begin
          w_state_nxt = ST_SYNC;
          w_good_nxt  = '0;
        end
        ST_SYNC: begin
          if (w_good_step) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == GOOD_W'(LOCK_STEPS)) begin
              w_state_nxt = ST_LOCKED;
            end
          end else if (w_step == STEP_ILLEGAL) begin
            w_good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (w_step == STEP_ILLEGAL) begin
            w_state_nxt = ST_SYNC;
            w_good_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_good_nxt  = '0;
        end
      endcase

      if ((r_state != ST_EMPTY) && (w_step == STEP_ILLEGAL)) begin
        w_step_err_nxt = 1'b1;
        if (r_err_count != ERR_MAX) begin
          w_err_count_nxt = r_err_count + ERR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_EMPTY;
      r_good      <= '0;
      r_pb        <= '0;
      r_bin_out   <= '0;
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_good      <= w_good_nxt;
      r_pb        <= w_pb_nxt;
      r_bin_out   <= w_bin_out_nxt;
      r_bin_valid <= w_bin_valid_nxt;
      r_step_err  <= w_step_err_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign mon_bus.bin_out   = r_bin_out;
  assign mon_bus.bin_valid = r_bin_valid;
  assign mon_bus.step_err  = r_step_err;
  assign mon_bus.err_count = r_err_count;
  assign mon_bus.locked    = (r_state == ST_LOCKED);

endmodule
